// File: rtl/game_fsm_pkg.sv
// Shared types and constants for the game sequencer: state encodings,
// output widths and the spawn LFSR step.
package game_fsm_pkg;

  typedef enum logic [2:0] {
    GS_IDLE  = 3'd0,
    GS_PLAY  = 3'd1,
    GS_PAUSE = 3'd2,
    GS_HIT   = 3'd3,
    GS_OVER  = 3'd4
  } game_state_e;

  localparam int          SCORE_BCD_LEN = 16;
  localparam int          LIVES_BIT_LEN = 2;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  // Right-shifting Galois LFSR, feedback from bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/game_fsm_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; sticks at all-nines.
module game_fsm_bcd_counter
  import game_fsm_pkg::*;
#(
  parameter int DIGITS = SCORE_BCD_LEN / 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   value
);

  logic [DIGITS-1:0][3:0] dig, dig_nxt;
  logic [DIGITS-1:0]      is9;
  logic [DIGITS-1:0]      carry;

  // Carry ripples up through digits sitting at 9; blocked entirely once all read 9.
  assign carry[0] = inc & ~(&is9);

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign is9[i]     = (dig[i] == 4'd9);
    assign dig_nxt[i] = carry[i] ? (is9[i] ? 4'd0 : dig[i] + 4'd1) : dig[i];
    if (i < DIGITS - 1) begin : g_carry
      assign carry[i+1] = carry[i] & is9[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dig <= '0;
    else if (clr) dig <= '0;
    else          dig <= dig_nxt;
  end

  assign value = dig;

endmodule

// File: rtl/game_fsm.sv
// Game sequencer in the pixel clock domain: state, lives, BCD score,
// player blink during invulnerability and LFSR-jittered enemy spawn timing.
module game_fsm
  import game_fsm_pkg::*;
#(
  parameter int          LIVES_INIT   = 3,
  parameter int          HIT_FRAMES   = 120,
  parameter int          BLINK_FRAMES = 8,
  parameter int          SPAWN_MIN    = 30,
  parameter logic [15:0] SPAWN_MASK   = 16'h003F,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_sync_i,
  input  logic                     start_i,
  input  logic                     pause_i,
  input  logic                     crash_me_enemy_i,
  input  logic                     crash_enemy_bullet_i,
  output logic [2:0]               state_o,
  output logic                     run_en_o,
  output logic                     me_visible_o,
  output logic [LIVES_BIT_LEN-1:0] lives_o,
  output logic [SCORE_BCD_LEN-1:0] score_o,
  output logic                     spawn_o,
  output logic                     game_over_o
);

  localparam logic [LIVES_BIT_LEN-1:0] LIVES_LD   = LIVES_BIT_LEN'(LIVES_INIT);
  localparam logic [15:0]              HIT_LD     = 16'(HIT_FRAMES);
  localparam logic [15:0]              BLINK_LAST = 16'(BLINK_FRAMES - 1);
  localparam logic [15:0]              SPAWN_LD   = 16'(SPAWN_MIN);

  game_state_e state;
  logic        v_sync_q, start_q, pause_q;
  logic        tick, start_rise, pause_rise;
  logic        active, kill_seen, score_inc, score_clr;
  logic [15:0] lfsr, spawn_cnt, hit_cnt, blink_cnt;

  assign tick       = v_sync_q & ~v_sync_i;
  assign start_rise = start_i & ~start_q;
  assign pause_rise = pause_i & ~pause_q;
  assign active     = (state == GS_PLAY) || (state == GS_HIT);
  assign score_inc  = active & crash_enemy_bullet_i & ~kill_seen;
  assign score_clr  = ((state == GS_IDLE) || (state == GS_OVER)) & start_rise;
  assign state_o    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_sync_q <= 1'b0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      lfsr     <= LFSR_SEED;
    end else begin
      v_sync_q <= v_sync_i;
      start_q  <= start_i;
      pause_q  <= pause_i;
      lfsr     <= lfsr_next(lfsr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GS_IDLE;
      run_en_o     <= 1'b0;
      me_visible_o <= 1'b1;
      lives_o      <= '0;
      spawn_o      <= 1'b0;
      game_over_o  <= 1'b0;
      hit_cnt      <= '0;
      blink_cnt    <= '0;
      spawn_cnt    <= '0;
      kill_seen    <= 1'b0;
    end else begin
      spawn_o <= 1'b0;
      // A kill in the tick cycle is still scored; the flag re-arms for the new frame.
      if (tick)           kill_seen <= 1'b0;
      else if (score_inc) kill_seen <= 1'b1;

      if (active && tick) begin
        if (spawn_cnt == 16'd0) begin
          spawn_o   <= 1'b1;
          spawn_cnt <= SPAWN_LD + (lfsr & SPAWN_MASK);
        end else begin
          spawn_cnt <= spawn_cnt - 16'd1;
        end
      end

      case (state)
        GS_IDLE, GS_OVER: begin
          if (start_rise) begin
            state        <= GS_PLAY;
            run_en_o     <= 1'b1;
            game_over_o  <= 1'b0;
            me_visible_o <= 1'b1;
            lives_o      <= LIVES_LD;
            spawn_cnt    <= SPAWN_LD;
          end
        end
        GS_PLAY: begin
          if (crash_me_enemy_i) begin
            if (lives_o == LIVES_BIT_LEN'(1)) begin
              lives_o     <= '0;
              state       <= GS_OVER;
              run_en_o    <= 1'b0;
              game_over_o <= 1'b1;
            end else begin
              lives_o      <= lives_o - LIVES_BIT_LEN'(1);
              state        <= GS_HIT;
              hit_cnt      <= HIT_LD;
              blink_cnt    <= '0;
              me_visible_o <= 1'b0;
            end
          end else if (pause_rise) begin
            state    <= GS_PAUSE;
            run_en_o <= 1'b0;
          end
        end
        GS_HIT: begin
          if (tick) begin
            if (hit_cnt == 16'd1) begin
              state        <= GS_PLAY;
              me_visible_o <= 1'b1;
            end else begin
              hit_cnt <= hit_cnt - 16'd1;
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                me_visible_o <= ~me_visible_o;
              end else begin
                blink_cnt <= blink_cnt + 16'd1;
              end
            end
          end
        end
        GS_PAUSE: begin
          if (pause_rise) begin
            state    <= GS_PLAY;
            run_en_o <= 1'b1;
          end
        end
        default: begin
          state       <= GS_IDLE;
          run_en_o    <= 1'b0;
          game_over_o <= 1'b0;
        end
      endcase
    end
  end

  game_fsm_bcd_counter u_score (
    .clk   (clk),
    .rst_n (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score_o)
  );

endmodule

// File: tb/tb_game_fsm.sv
// Randomized bench for game_fsm against an integer-score game model.
module tb_game_fsm;

  localparam int          LIVES_INIT   = 3;
  localparam int          HIT_FRAMES   = 120;
  localparam int          BLINK_FRAMES = 8;
  localparam int          SPAWN_MIN    = 30;
  localparam logic [15:0] SPAWN_MASK   = 16'h0000;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_HIT = 3, S_OVER = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        v_sync = 1'b0, start = 1'b0, pause = 1'b0, crash_me = 1'b0, crash_bul = 1'b0;
  logic [2:0]  state_o;
  logic        run_en_o, me_visible_o, spawn_o, game_over_o;
  logic [1:0]  lives_o;
  logic [15:0] score_o;

  game_fsm #(
    .LIVES_INIT(LIVES_INIT), .HIT_FRAMES(HIT_FRAMES), .BLINK_FRAMES(BLINK_FRAMES),
    .SPAWN_MIN(SPAWN_MIN), .SPAWN_MASK(SPAWN_MASK), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk(clk), .rst(rst), .v_sync_i(v_sync), .start_i(start), .pause_i(pause),
    .crash_me_enemy_i(crash_me), .crash_enemy_bullet_i(crash_bul),
    .state_o(state_o), .run_en_o(run_en_o), .me_visible_o(me_visible_o),
    .lives_o(lives_o), .score_o(score_o), .spawn_o(spawn_o), .game_over_o(game_over_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: score kept as a plain integer, state as an int.
  int          m_state, m_lives, m_score, m_hit, m_blink, m_spawn_cnt;
  bit          m_kill, m_vis, m_spawn, m_vq, m_sq, m_pq;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_state = S_IDLE; m_lives = 0; m_score = 0; m_hit = 0; m_blink = 0; m_spawn_cnt = 0;
    m_kill = 0; m_vis = 1; m_spawn = 0; m_vq = 0; m_sq = 0; m_pq = 0; m_lfsr = LFSR_SEED;
  endtask

  task automatic model_step(input bit vs, input bit st, input bit pa, input bit cm, input bit cb);
    bit tick, srise, prise, playing;
    tick    = m_vq && !vs;
    srise   = st && !m_sq;
    prise   = pa && !m_pq;
    playing = (m_state == S_PLAY) || (m_state == S_HIT);
    m_spawn = 0;
    if (playing && cb && !m_kill) begin
      if (m_score < 9999) m_score++;
      m_kill = 1;
    end
    if (tick) m_kill = 0;
    if (playing && tick) begin
      if (m_spawn_cnt == 0) begin
        m_spawn = 1;
        m_spawn_cnt = SPAWN_MIN + int'(m_lfsr & SPAWN_MASK);
      end else m_spawn_cnt--;
    end
    case (m_state)
      S_IDLE, S_OVER: if (srise) begin
        m_state = S_PLAY; m_lives = LIVES_INIT; m_score = 0; m_spawn_cnt = SPAWN_MIN; m_vis = 1;
      end
      S_PLAY: begin
        if (cm) begin
          if (m_lives == 1) begin m_lives = 0; m_state = S_OVER; end
          else begin m_lives--; m_state = S_HIT; m_hit = HIT_FRAMES; m_blink = 0; m_vis = 0; end
        end else if (prise) m_state = S_PAUSE;
      end
      S_HIT: if (tick) begin
        if (m_hit == 1) begin m_state = S_PLAY; m_vis = 1; end
        else begin
          m_hit--;
          m_blink++;
          if (m_blink == BLINK_FRAMES) begin m_blink = 0; m_vis = !m_vis; end
        end
      end
      S_PAUSE: if (prise) m_state = S_PLAY;
      default: ;
    endcase
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    m_vq = vs; m_sq = st; m_pq = pa;
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [31:0] exp_vec();
    bit run, go;
    run = (m_state == S_PLAY) || (m_state == S_HIT);
    go  = (m_state == S_OVER);
    return 32'({3'(m_state), run, m_vis, 2'(m_lives), to_bcd(m_score), m_spawn, go});
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({state_o, run_en_o, me_visible_o, lives_o, score_o, spawn_o, game_over_o});
  endfunction

  // Called at a negedge; applies one cycle of inputs and checks the result.
  task automatic step(input bit vs, input bit st, input bit pa, input bit cm, input bit cb);
    v_sync = vs; start = st; pause = pa; crash_me = cm; crash_bul = cb;
    model_step(vs, st, pa, cm, cb);
    @(posedge clk); #1;
    chk("outs", obs_vec(), exp_vec());
    @(negedge clk);
  endtask

  // Reset asserted between edges with crash/pause active; must clear at once.
  task automatic reset_mid();
    #2;
    crash_me = 1'b1; pause = 1'b1; crash_bul = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_async", obs_vec(), exp_vec());
    @(posedge clk); #1;
    chk("rst_hold", obs_vec(), exp_vec());
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit st_l = 0, pa_l = 0, cb_l = 0, cm;
    int cm_left = 0, n_rst = 0;
    model_reset();
    @(negedge clk);
    chk("reset", obs_vec(), exp_vec());
    chk("reset_vis", 32'(me_visible_o), 32'd1);
    rst = 1'b1;

    step(0, 1, 0, 0, 0);
    chk("start_state", 32'(state_o), 32'd1);
    chk("start_lives", 32'(lives_o), 32'd3);
    step(0, 0, 0, 0, 0);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) st_l = !st_l;
      if ($urandom_range(0, 299) == 0) pa_l = !pa_l;
      if ($urandom_range(0, 15) == 0)  cb_l = !cb_l;
      if (cm_left == 0 && $urandom_range(0, 399) == 0) cm_left = $urandom_range(1, 12);
      cm = (cm_left != 0);
      if (cm_left != 0) cm_left--;
      step($urandom_range(0, 3) == 0, st_l, pa_l, cm, cb_l);
      if (m_state == S_HIT && n_rst < 3 && $urandom_range(0, 299) == 0) begin
        reset_mid();
        n_rst++;
      end
    end

    // Directed run: one kill per frame up to saturation, with a long pause in between.
    reset_mid();
    step(0, 1, 0, 0, 0);
    for (int f = 0; f < 10020; f++) begin
      if (f == 200) begin
        step(0, 1, 1, 0, 1);
        chk("pause_state", 32'(state_o), 32'd2);
        for (int k = 0; k < 50; k++) begin
          step(1, 1, 0, 0, 1);
          step(0, 1, 0, 0, 1);
        end
        step(0, 1, 1, 0, 1);
        chk("resume_state", 32'(state_o), 32'd1);
      end
      step(1, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
    end
    chk("score_sat", 32'(score_o), 32'h9999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
